// File: rtl/fp_divider.sv
// Multi-cycle single-precision divider z = x / y: restoring mantissa division,
// one quotient bit per enabled cycle, truncated result, denormals flushed to zero.
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);

    localparam logic [4:0] S_DONE = 5'd27;

    logic [4:0]  s_reg, s_next;
    logic [24:0] r_reg, r_next;
    logic [25:0] q_reg, q_next;

    logic [23:0] mx, my;
    logic [24:0] my_ext;
    logic [24:0] diff;
    logic        ge;

    assign mx     = {1'b1, x[22:0]};
    assign my     = {1'b1, y[22:0]};
    assign my_ext = {1'b0, my};
    assign ge     = (r_reg >= my_ext);
    assign diff   = ge ? (r_reg - my_ext) : r_reg;

    always_comb begin
        s_next = s_reg;
        r_next = r_reg;
        q_next = q_reg;
        if (s_reg == 5'd0) begin
            r_next = {1'b0, mx};
            q_next = '0;
        end else if (s_reg != S_DONE) begin
            // Remainder stays below 2*my, so the dropped MSB is always zero.
            r_next = {diff[23:0], 1'b0};
            q_next = {q_reg[24:0], ge};
        end
        if (!run)
            s_next = 5'd0;
        else if (s_reg != S_DONE)
            s_next = s_reg + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg <= '0;
            r_reg <= '0;
            q_reg <= '0;
        end else if (enable) begin
            s_reg <= s_next;
            r_reg <= r_next;
            q_reg <= q_next;
        end
    end

    assign stall = run && (s_reg != S_DONE);

    // Result packing: quotient lies in (0.5, 2), Q[25] selects the normalisation.
    logic [7:0]        xe, ye;
    logic              sign;
    logic signed [9:0] e1;
    logic [22:0]       frac;

    assign xe   = x[30:23];
    assign ye   = y[30:23];
    assign sign = x[31] ^ y[31];
    assign e1   = $signed({2'b00, xe}) - $signed({2'b00, ye})
                + $signed(10'sd126) + $signed({9'b0, q_reg[25]});
    assign frac = q_reg[25] ? q_reg[24:2] : q_reg[23:1];

    always_comb begin
        z = {sign, e1[7:0], frac};
        if (xe == 8'd0)
            z = 32'd0;
        else if (ye == 8'd0)
            z = {sign, 8'hFF, 23'd0};
        else if (e1 <= 10'sd0)
            z = 32'd0;
        else if (e1 >= 10'sd255)
            z = {sign, 8'hFF, 23'd0};
    end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: integer-division reference model, per-cycle
// compare of stall/z, directed vectors with literal results, and random operands.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        run;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] z;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    int busy_cycles = 0;

    fp_divider dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .run    (run),
        .x      (x),
        .y      (y),
        .stall  (stall),
        .z      (z)
    );

    always #5 clk = ~clk;

    // Reference: quotient as a plain integer division of the mantissas.
    function automatic logic [31:0] model_z(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] q;
        logic [63:0] mxa, myb;
        int          e1;
        logic        s;
        logic        top;
        logic [22:0] f;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0) return 32'd0;
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
        mxa = {40'd0, 1'b1, a[22:0]};
        myb = {40'd0, 1'b1, b[22:0]};
        q   = (mxa << 25) / myb;
        top = q[25];
        e1  = int'(a[30:23]) - int'(b[30:23]) + 126 + (top ? 1 : 0);
        if (e1 <= 0)   return 32'd0;
        if (e1 >= 255) return {s, 8'hFF, 23'd0};
        f = top ? q[24:2] : q[23:1];
        return {s, 8'(e1), f};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timing model: number of enabled run cycles since the operation (re)started, capped.
    always @(posedge clk) begin
        if (rst)
            busy_cycles <= 0;
        else if (enable)
            busy_cycles <= run ? ((busy_cycles >= 27) ? 27 : busy_cycles + 1) : 0;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic exp_stall;
            exp_stall = run && (busy_cycles < 27);
            check32("cycle_stall", {31'd0, stall}, {31'd0, exp_stall});
            if (run && !exp_stall)
                check32("cycle_z", z, model_z(x, y));
        end
    end

    // mode: 0 plain, 1 enable pause, 2 run drop, 3 reset pulse, 4 random enable
    task automatic do_div(input string name, input logic [31:0] xa, input logic [31:0] ya,
                          input int mode, input int at, input int len,
                          input bit use_lit, input logic [31:0] zlit, input int exp_stalls);
        int  cyc;
        int  cnt;
        bit  done;
        x = xa;
        y = ya;
        run = 1'b1;
        enable = 1'b1;
        cyc = 0;
        cnt = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            if (run && !stall) done = 1'b1;
            else if (run && stall) cnt++;
            if (!done) begin
                @(posedge clk);
                #1;
                cyc++;
                case (mode)
                    1: enable = !(cyc >= at && cyc < at + len);
                    2: run    = (cyc != at);
                    3: rst    = (cyc == at);
                    4: enable = ($urandom_range(3) != 0);
                    default: ;
                endcase
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s timeout: got stall still high expected completion", name);
        end
        if (exp_stalls >= 0) check_int({name, "_stalls"}, cnt, exp_stalls);
        check32({name, "_z_model"}, z, model_z(xa, ya));
        if (use_lit) begin
            check32({name, "_z_lit"}, z, zlit);
            check32({name, "_model_lit"}, model_z(xa, ya), zlit);
        end
        $display("[TB] %s x=%h y=%h z=%h expected=%h stall_cycles=%0d", name, xa, ya, z,
                 use_lit ? zlit : model_z(xa, ya), cnt);
        @(posedge clk);
        #1;
        run = 1'b0;
        enable = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(1) == 0)
            v[30:23] = 8'(110 + $urandom_range(35));
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        run = 1'b0;
        enable = 1'b1;
        x = 32'd0;
        y = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        check32("reset_stall", {31'd0, stall}, 32'd0);
        check32("reset_z", z, 32'd0);
        @(posedge clk);
        #1;

        do_div("div_6_2",      32'h40C00000, 32'h40000000, 0, 0, 0, 1, 32'h40400000, 27);
        do_div("div_1_3",      32'h3F800000, 32'h40400000, 0, 0, 0, 1, 32'h3EAAAAAA, 27);
        do_div("div_m75_25",   32'hC0F00000, 32'h40200000, 0, 0, 0, 1, 32'hC0400000, 27);
        do_div("div_by_zero",  32'h3F800000, 32'h00000000, 0, 0, 0, 1, 32'h7F800000, 27);
        do_div("zero_div",     32'h00000000, 32'h40000000, 0, 0, 0, 1, 32'h00000000, 27);
        do_div("neg_by_zero",  32'h80800000, 32'h00000000, 0, 0, 0, 1, 32'hFF800000, 27);
        do_div("underflow",    32'h00800000, 32'h40000000, 0, 0, 0, 1, 32'h00000000, 27);
        do_div("overflow",     32'h7F000000, 32'h3F000000, 0, 0, 0, 1, 32'h7F800000, 27);
        do_div("largest",      32'h7F000000, 32'h3F800000, 0, 0, 0, 1, 32'h7F000000, 27);
        do_div("equal_mant",   32'h40A00000, 32'h3FA00000, 0, 0, 0, 1, 32'h40800000, 27);
        do_div("enable_pause", 32'h40C00000, 32'h40000000, 1, 10, 5, 1, 32'h40400000, 32);
        do_div("run_drop",     32'h3F800000, 32'h40400000, 2, 12, 0, 1, 32'h3EAAAAAA, 12 + 27);
        do_div("reset_mid",    32'hC0F00000, 32'h40200000, 3, 15, 0, 1, 32'hC0400000, 16 + 27);

        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check32("rst_run0_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check32("after_rst_stall", {31'd0, stall}, 32'd0);
        $display("[TB] rst_with_run0 stall=%0d expected=0", stall);
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = rand_operand();
            rb = rand_operand();
            if (i % 7 == 3) rb[22:0] = ra[22:0];
            do_div("rand", ra, rb, 0, 0, 0, 0, 32'd0, 27);
        end
        for (int i = 0; i < 10; i++)
            do_div("rand_en", rand_operand(), rand_operand(), 4, 0, 0, 0, 32'd0, -1);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
